aes_dom_sequencer: RTL and testbench
====================================

Name: aes_dom_sequencer

Overview:
- Host-side driver for the byte-serial masked DOM AES core; sits on the other end of the core's PT/K/Start/Done/C interface.
- Accepts a 128-bit plaintext and key over a valid/ready handshake.
- Splits each byte into N_share+1 Boolean shares and streams them into the core.
- Collects the 16 shared ciphertext bytes, recombines them, and returns a 128-bit ciphertext over a second valid/ready handshake.

Parameters:
- N_share, 1, masking order; share count = N_share+1; legal range ≥1.
- TIMEOUT, 1023, maximum cycles spent in WAIT before the error flag is raised.

Ports:
- ClkxCI  in  1  clock
- RstxBI  in  1  asynchronous active-low reset
- PlainxDI  in  128  plaintext; byte 0 = [127:120]
- KeyxDI  in  128  key; byte 0 = [127:120]
- InValidxSI  in  1  plaintext/key valid
- InReadyxSO  out  1  sequencer can accept a request
- MaskxDI  in  16*N_share  fresh masks per LOAD cycle; [8*N_share-1:0] for PT, upper half for K
- CipherxDO  out  128  unmasked ciphertext; byte 0 = [127:120]
- OutValidxSO  out  1  ciphertext valid
- OutReadyxSI  in  1  consumer accepts ciphertext
- AesPTxDO  out  8*(N_share+1)  PT shares to core; share i at [8i+7:8i]
- AesKxDO  out  8*(N_share+1)  key shares to core, same layout
- AesStartxSO  out  1  start pulse to core
- AesDonexSI  in  1  core done/ciphertext-valid
- AesCxDI  in  8*(N_share+1)  ciphertext shares from core
- ErrorxSO  out  1  sticky protocol/timeout error

Behaviour:
- Reset (RstxBI=0, asynchronous, any state): state=IDLE, all counters 0, all registers 0.
  - Outputs: InReadyxSO=1, OutValidxSO=0, AesStartxSO=0, AesPTxDO=0, AesKxDO=0, CipherxDO=0, ErrorxSO=0.
- Core protocol (fixed):
  - AesStartxSO is high for exactly one cycle, concurrent with byte 0.
  - Bytes 0..15 are driven on 16 consecutive cycles.
  - The core then raises AesDonexSI for 16 consecutive cycles, carrying ciphertext bytes 0..15.
- Masking, per byte b and per LOAD cycle:
  - Shares 1..N_share = successive 8-bit slices of MaskxDI.
  - Share 0 = b XOR all mask slices.
  - Masks are sampled combinationally in the same cycle as the byte they protect.
- Unmasking: ciphertext byte = XOR of all N_share+1 shares of AesCxDI.
- IDLE:
  - InReadyxSO=1.
  - On InValidxSI & InReadyxSO, register PlainxDI and KeyxDI and go to LOAD.
  - ErrorxSO is cleared on this acceptance.
- LOAD (16 cycles, byte counter 0..15):
  - Drive byte[cnt] shares onto AesPTxDO and AesKxDO.
  - AesStartxSO=1 only when cnt=0.
  - After cnt=15, go to WAIT.
  - Outside LOAD, AesPTxDO and AesKxDO are driven to 0.
- WAIT:
  - Timeout counter increments each cycle.
  - On AesDonexSI=1, capture byte 0 in that same cycle and go to COLLECT with cnt=1.
  - If the counter reaches TIMEOUT with no Done, set ErrorxSO and return to IDLE.
- COLLECT:
  - Capture byte[cnt] each cycle while AesDonexSI=1.
  - After byte 15 is captured, go to OUT.
  - If AesDonexSI drops before byte 15: set ErrorxSO, discard the partial ciphertext, return to IDLE.
- Done outside WAIT/COLLECT:
  - AesDonexSI=1 in IDLE, LOAD or OUT sets ErrorxSO and is otherwise ignored.
  - In LOAD the state is unaffected.
- OUT:
  - OutValidxSO=1 and CipherxDO stable until OutValidxSO & OutReadyxSI, then go to IDLE.
  - InReadyxSO=0 in every state except IDLE.
- Latency: request accepted at cycle t, then:
  - Start at t+1.
  - Last load byte at t+16.
  - OutValidxSO at (cycle of last Done byte)+1.
- Input stability: input changes while not in IDLE have no effect.
- Reset mid-operation: abandons the current block. The core must be reset in the same reset domain.

Test Plan:
- FIPS-197 C.1 with a behavioural core model: key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff, MaskxDI random, OutReady=1 -> CipherxDO=69c4e0d86a7b0430d8cdb78070b4c55a. Check that the XOR of AesPTxDO shares equals the PT byte every LOAD cycle and that Start is high only on the first byte.
- MaskxDI=0 -> share0 equals the raw byte and shares 1..N are 0. MaskxDI=all-ones, N_share=1 -> share0 = ~byte.
- Backpressure: OutReadyxSI held 0 for 20 cycles -> OutValidxSO stays 1, CipherxDO is constant, InReadyxSO=0. Ready=1 -> IDLE next cycle, InReadyxSO=1.
- Timeout with TIMEOUT=8, core never asserts Done -> ErrorxSO=1 eight cycles after the last LOAD byte, return to IDLE, OutValidxSO never asserted.
- AesDonexSI dropped after 5 bytes -> ErrorxSO=1, IDLE, no OutValid. Next request -> ErrorxSO clears and a correct ciphertext is produced.
- RstxBI pulsed low at LOAD byte 7 -> all outputs at reset values immediately; a subsequent request completes normally.

Source files
------------

// File: rtl/aes_dom_sequencer.sv
// Host-side sequencer for the byte-serial masked DOM AES core: shares plaintext/key
// bytes into the core, then recombines the 16 shared ciphertext bytes it returns.
module aes_dom_sequencer #(
    parameter int N_share = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                     ClkxCI,
    input  logic                     RstxBI,
    input  logic [127:0]             PlainxDI,
    input  logic [127:0]             KeyxDI,
    input  logic                     InValidxSI,
    output logic                     InReadyxSO,
    input  logic [16*N_share-1:0]    MaskxDI,
    output logic [127:0]             CipherxDO,
    output logic                     OutValidxSO,
    input  logic                     OutReadyxSI,
    output logic [8*(N_share+1)-1:0] AesPTxDO,
    output logic [8*(N_share+1)-1:0] AesKxDO,
    output logic                     AesStartxSO,
    input  logic                     AesDonexSI,
    input  logic [8*(N_share+1)-1:0] AesCxDI,
    output logic                     ErrorxSO
);

    localparam int SHARES = N_share + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, OUT} state_t;

    state_t         state, stateNext;
    logic [127:0]   ptReg, keyReg, cipherReg;
    logic [3:0]     cnt;
    logic [TW-1:0]  timer;
    logic           errorReg;
    logic           accept, capture, errSet, abort;
    logic [7:0]     ptByte, keyByte, ptShare0, keyShare0, unmasked;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state     <= IDLE;
            ptReg     <= '0;
            keyReg    <= '0;
            cipherReg <= '0;
            cnt       <= '0;
            timer     <= '0;
            errorReg  <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                ptReg  <= PlainxDI;
                keyReg <= KeyxDI;
            end
            if (state == LOAD || capture) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
            if (state == WAIT) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            // Byte index counts from the MSB end, so ~cnt selects byte cnt.
            if (capture) begin
                cipherReg[{~cnt, 3'b000} +: 8] <= unmasked;
            end else if (abort) begin
                cipherReg <= '0;
            end
            if (errSet) begin
                errorReg <= 1'b1;
            end else if (accept) begin
                errorReg <= 1'b0;
            end
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        capture   = 1'b0;
        errSet    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (InValidxSI) begin
                    accept    = 1'b1;
                    stateNext = LOAD;
                end
                if (AesDonexSI) errSet = 1'b1;
            end
            LOAD: begin
                if (cnt == 4'd15) stateNext = WAIT;
                if (AesDonexSI) errSet = 1'b1;
            end
            WAIT: begin
                if (AesDonexSI) begin
                    capture   = 1'b1;
                    stateNext = COLLECT;
                end else if (timer == TIMEOUT_LAST) begin
                    errSet    = 1'b1;
                    stateNext = IDLE;
                end
            end
            COLLECT: begin
                if (AesDonexSI) begin
                    capture = 1'b1;
                    if (cnt == 4'd15) stateNext = OUT;
                end else begin
                    errSet    = 1'b1;
                    abort     = 1'b1;
                    stateNext = IDLE;
                end
            end
            OUT: begin
                if (OutReadyxSI) stateNext = IDLE;
                if (AesDonexSI) errSet = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Share 0 absorbs every mask slice so the XOR of all shares is the raw byte.
    always_comb begin
        ptByte    = ptReg[{~cnt, 3'b000} +: 8];
        keyByte   = keyReg[{~cnt, 3'b000} +: 8];
        ptShare0  = ptByte;
        keyShare0 = keyByte;
        AesPTxDO  = '0;
        AesKxDO   = '0;
        if (state == LOAD) begin
            for (int i = 1; i < SHARES; i++) begin
                ptShare0         = ptShare0 ^ MaskxDI[8*(i-1) +: 8];
                keyShare0        = keyShare0 ^ MaskxDI[8*N_share + 8*(i-1) +: 8];
                AesPTxDO[8*i +: 8] = MaskxDI[8*(i-1) +: 8];
                AesKxDO[8*i +: 8]  = MaskxDI[8*N_share + 8*(i-1) +: 8];
            end
            AesPTxDO[7:0] = ptShare0;
            AesKxDO[7:0]  = keyShare0;
        end
    end

    always_comb begin
        unmasked = '0;
        for (int i = 0; i < SHARES; i++) begin
            unmasked = unmasked ^ AesCxDI[8*i +: 8];
        end
    end

    assign InReadyxSO  = (state == IDLE);
    assign OutValidxSO = (state == OUT);
    assign AesStartxSO = (state == LOAD) && (cnt == 4'd0);
    assign CipherxDO   = cipherReg;
    assign ErrorxSO    = errorReg;

endmodule

// File: tb/tb_aes_dom_sequencer.sv
// Directed bench for aes_dom_sequencer; the bench itself plays the AES core and
// replies with the known FIPS-197 ciphertexts as freshly masked shares.
module tb_aes_dom_sequencer;

    localparam int N = 1;
    localparam int TO = 8;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;

    logic           clk = 1'b0;
    logic           rstN;
    logic [127:0]   plain, key, cipher;
    logic           inValid, inReady, outValid, outReady;
    logic [15:0]    mask;
    logic [15:0]    aesPT, aesK, aesC;
    logic           aesStart, aesDone, error;

    int nChecks = 0;
    int nFail = 0;

    aes_dom_sequencer #(.N_share(N), .TIMEOUT(TO)) dut (
        .ClkxCI(clk), .RstxBI(rstN),
        .PlainxDI(plain), .KeyxDI(key),
        .InValidxSI(inValid), .InReadyxSO(inReady),
        .MaskxDI(mask),
        .CipherxDO(cipher), .OutValidxSO(outValid), .OutReadyxSI(outReady),
        .AesPTxDO(aesPT), .AesKxDO(aesK), .AesStartxSO(aesStart),
        .AesDonexSI(aesDone), .AesCxDI(aesC),
        .ErrorxSO(error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of LOAD byte 0.
    task automatic requestBlock(input logic [127:0] pt, input logic [127:0] k);
        plain   = pt;
        key     = k;
        inValid = 1'b1;
        #1 checkOutput("inReadyIdle", inReady, 1);
        @(negedge clk);
        inValid = 1'b0;
        plain   = ~pt;
        key     = ~k;
        #1 checkOutput("inReadyBusy", inReady, 0);
    endtask

    // mode 0: zero masks, 1: all-ones masks, otherwise random masks.
    task automatic applyStimulus(input int mode, input int first, input int last,
                                 input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] pb, kb;
        for (int i = first; i <= last; i++) begin
            case (mode)
                0:       mask = 16'h0000;
                1:       mask = 16'hffff;
                default: mask = 16'($urandom);
            endcase
            pb = pt[127-8*i -: 8];
            kb = k[127-8*i -: 8];
            #1;
            checkOutput($sformatf("start%0d", i), aesStart, (i == 0));
            checkOutput($sformatf("ptXor%0d", i), aesPT[7:0] ^ aesPT[15:8], pb);
            checkOutput($sformatf("keyXor%0d", i), aesK[7:0] ^ aesK[15:8], kb);
            checkOutput($sformatf("keyMask%0d", i), aesK[15:8], mask[15:8]);
            if (mode == 0) checkOutput($sformatf("ptZeroMask%0d", i), aesPT, {8'h00, pb});
            if (mode == 1) checkOutput($sformatf("ptOnesMask%0d", i), aesPT, {8'hff, ~pb});
            @(negedge clk);
        end
    endtask

    // Called at the first WAIT negedge; plays the core's Done burst.
    task automatic coreReply(input logic [127:0] ct, input int nBytes, input int delay);
        logic [7:0] m;
        repeat (delay) @(negedge clk);
        for (int b = 0; b < nBytes; b++) begin
            m       = 8'($urandom);
            aesDone = 1'b1;
            aesC    = {m, ct[127-8*b -: 8] ^ m};
            @(negedge clk);
        end
        aesDone = 1'b0;
        aesC    = '0;
    endtask

    initial begin
        rstN = 1'b0; plain = '0; key = '0; inValid = 1'b0; mask = '0;
        outReady = 1'b1; aesDone = 1'b0; aesC = '0;
        #1;
        checkOutput("rstInReady", inReady, 1);
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstStart", aesStart, 0);
        checkOutput("rstPT", aesPT, 0);
        checkOutput("rstK", aesK, 0);
        checkOutput("rstCipher", cipher, 0);
        checkOutput("rstError", error, 0);
        @(negedge clk); rstN = 1'b1;
        @(negedge clk);

        $display("[TB] FIPS-197 C.1 with random masks");
        requestBlock(FIPS_PT, FIPS_KEY);
        applyStimulus(2, 0, 15, FIPS_PT, FIPS_KEY);
        coreReply(FIPS_CT, 16, 2);
        #1;
        checkOutput("fipsOutValid", outValid, 1);
        checkOutput("fipsCipher", cipher, FIPS_CT);
        checkOutput("fipsInReady", inReady, 0);
        checkOutput("fipsPTIdle", aesPT, 0);
        @(negedge clk); #1;
        checkOutput("fipsBackIdle", inReady, 1);
        checkOutput("fipsOutValidLow", outValid, 0);
        checkOutput("fipsError", error, 0);

        $display("[TB] zero masks with backpressure");
        outReady = 1'b0;
        @(negedge clk);
        requestBlock(B_PT, B_KEY);
        applyStimulus(0, 0, 15, B_PT, B_KEY);
        coreReply(B_CT, 16, 0);
        for (int c = 0; c < 20; c++) begin
            #1;
            checkOutput("bpOutValid", outValid, 1);
            checkOutput("bpCipher", cipher, B_CT);
            checkOutput("bpInReady", inReady, 0);
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk); #1;
        checkOutput("bpReleaseReady", inReady, 1);
        checkOutput("bpReleaseValid", outValid, 0);

        $display("[TB] all-ones masks, core never answers");
        @(negedge clk);
        requestBlock(FIPS_PT, FIPS_KEY);
        applyStimulus(1, 0, 15, FIPS_PT, FIPS_KEY);
        for (int c = 0; c < TO; c++) begin
            #1;
            checkOutput($sformatf("toWaitError%0d", c), error, 0);
            checkOutput("toWaitValid", outValid, 0);
            @(negedge clk);
        end
        #1;
        checkOutput("toError", error, 1);
        checkOutput("toIdle", inReady, 1);
        checkOutput("toOutValid", outValid, 0);

        $display("[TB] Done dropped after five bytes");
        @(negedge clk);
        requestBlock(FIPS_PT, FIPS_KEY);
        checkOutput("dropErrCleared", error, 0);
        applyStimulus(2, 0, 15, FIPS_PT, FIPS_KEY);
        coreReply(FIPS_CT, 5, 1);
        #1 checkOutput("dropValidCollect", outValid, 0);
        @(negedge clk); #1;
        checkOutput("dropError", error, 1);
        checkOutput("dropIdle", inReady, 1);
        checkOutput("dropOutValid", outValid, 0);
        checkOutput("dropCipher", cipher, 0);
        @(negedge clk);
        requestBlock(FIPS_PT, FIPS_KEY);
        checkOutput("retryErrCleared", error, 0);
        applyStimulus(2, 0, 15, FIPS_PT, FIPS_KEY);
        coreReply(FIPS_CT, 16, 3);
        #1;
        checkOutput("retryOutValid", outValid, 1);
        checkOutput("retryCipher", cipher, FIPS_CT);
        @(negedge clk);

        $display("[TB] stray Done in IDLE and LOAD, then reset at byte 7");
        aesDone = 1'b1;
        @(negedge clk);
        aesDone = 1'b0;
        #1 checkOutput("idleDoneError", error, 1);
        @(negedge clk);
        requestBlock(B_PT, B_KEY);
        applyStimulus(2, 0, 2, B_PT, B_KEY);
        aesDone = 1'b1;
        applyStimulus(2, 3, 3, B_PT, B_KEY);
        aesDone = 1'b0;
        checkOutput("loadDoneError", error, 1);
        applyStimulus(2, 4, 6, B_PT, B_KEY);
        mask = 16'h5aa5;
        rstN = 1'b0;
        #1;
        checkOutput("midRstInReady", inReady, 1);
        checkOutput("midRstOutValid", outValid, 0);
        checkOutput("midRstStart", aesStart, 0);
        checkOutput("midRstPT", aesPT, 0);
        checkOutput("midRstK", aesK, 0);
        checkOutput("midRstCipher", cipher, 0);
        checkOutput("midRstError", error, 0);
        @(negedge clk); rstN = 1'b1;
        @(negedge clk);
        requestBlock(B_PT, B_KEY);
        applyStimulus(2, 0, 15, B_PT, B_KEY);
        coreReply(B_CT, 16, 0);
        #1;
        checkOutput("postRstOutValid", outValid, 1);
        checkOutput("postRstCipher", cipher, B_CT);
        @(negedge clk); #1;
        checkOutput("postRstIdle", inReady, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
